// File: rtl/btb_pkg.sv
// Shared BTB geometry, the pending-update record, and the update-controller state encoding.
package btb_pkg;

  localparam int SET_COUNT   = 4;
  localparam int N           = 4;
  localparam int INDEX_WIDTH = 2;
  localparam int BIA_WIDTH   = 60;
  localparam int ADDR_WIDTH  = 64;
  localparam int WAY_WIDTH   = $clog2(N);

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    logic [WAY_WIDTH-1:0]   way;
    logic [BIA_WIDTH-1:0]   bia;
    logic [ADDR_WIDTH-1:0]  target;
  } btb_upd_t;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of pending BTB updates; clear discards everything queued.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_arst,
  input  logic     i_push,
  input  logic     i_pop,
  input  logic     i_clear,
  input  btb_upd_t i_data,
  output btb_upd_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  btb_upd_t    r_mem [DEPTH];
  logic        w_doPush;
  logic        w_doPop;

  // Extra pointer MSB tells a full ring from an empty one.
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_head   = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_doPush && !i_clear) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Sole driver of the BTB write port: drains queued taken-branch updates and
// performs set-by-set invalidation walks on flush requests.
module btb_update_ctrl #(
  parameter int SET_COUNT   = btb_pkg::SET_COUNT,
  parameter int N           = btb_pkg::N,
  parameter int INDEX_WIDTH = btb_pkg::INDEX_WIDTH,
  parameter int BIA_WIDTH   = btb_pkg::BIA_WIDTH,
  parameter int ADDR_WIDTH  = btb_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_stall_fetch,
  input  logic                   i_upd_valid,
  output logic                   o_upd_ready,
  input  logic                   i_upd_taken,
  input  logic [$clog2(N)-1:0]   i_upd_way,
  input  logic [INDEX_WIDTH-1:0] i_upd_index,
  input  logic [BIA_WIDTH-1:0]   i_upd_bia,
  input  logic [ADDR_WIDTH-1:0]  i_upd_target,
  input  logic                   i_flush_req,
  output logic                   o_flush_busy,
  output logic                   o_flush_done,
  output logic                   o_wr_en,
  output logic                   o_wr_valid,
  output logic [INDEX_WIDTH-1:0] o_wr_index,
  output logic [$clog2(N)-1:0]   o_wr_way,
  output logic [BIA_WIDTH-1:0]   o_wr_bia,
  output logic [ADDR_WIDTH-1:0]  o_wr_target
);

  import btb_pkg::*;

  ctrl_state_t            r_state;
  ctrl_state_t            w_nextState;
  logic [INDEX_WIDTH-1:0] r_setCount;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_clear;
  logic                   w_lastSet;
  btb_upd_t               w_updIn;
  btb_upd_t               w_head;

  assign o_upd_ready  = (r_state == IDLE) && !w_full && !i_flush_req;
  assign w_push       = i_upd_valid && o_upd_ready && i_upd_taken;
  assign w_pop        = (r_state == IDLE) && !w_empty && !i_stall_fetch;
  assign w_clear      = (r_state == IDLE) && i_flush_req;
  assign w_lastSet    = (r_setCount == INDEX_WIDTH'(SET_COUNT - 1));
  assign o_flush_busy = (r_state == FLUSH);
  assign o_flush_done = (r_state == DONE);

  assign w_updIn = '{index: i_upd_index, way: i_upd_way, bia: i_upd_bia, target: i_upd_target};

  btb_upd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_arst (i_arst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_clear(w_clear),
    .i_data (w_updIn),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state    <= IDLE;
      r_setCount <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_clear) begin
        r_setCount <= '0;
      end else if ((r_state == FLUSH) && !w_lastSet) begin
        r_setCount <= r_setCount + INDEX_WIDTH'(1);
      end
    end
  end

  // Write data is zeroed whenever no write is issued; invalidation ignores fetch stall.
  always_comb begin
    w_nextState = r_state;
    o_wr_en     = 1'b0;
    o_wr_valid  = 1'b1;
    o_wr_index  = '0;
    o_wr_way    = '0;
    o_wr_bia    = '0;
    o_wr_target = '0;
    case (r_state)
      IDLE: begin
        if (i_flush_req) w_nextState = FLUSH;
        if (w_pop) begin
          o_wr_en     = 1'b1;
          o_wr_index  = w_head.index;
          o_wr_way    = w_head.way;
          o_wr_bia    = w_head.bia;
          o_wr_target = w_head.target;
        end
      end
      FLUSH: begin
        o_wr_en    = 1'b1;
        o_wr_valid = 1'b0;
        o_wr_index = r_setCount;
        if (w_lastSet) w_nextState = DONE;
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed, table-driven bench for btb_update_ctrl plus hand-written fill, flush and reset sequences.
module tb_btb_update_ctrl;

  typedef struct packed {
    logic        stall;
    logic        valid;
    logic        taken;
    logic [1:0]  way;
    logic [1:0]  index;
    logic [59:0] bia;
    logic [63:0] target;
    logic        flush;
  } stim_t;

  typedef struct packed {
    logic        ready;
    logic        wrEn;
    logic        wrValid;
    logic [1:0]  wrIndex;
    logic [1:0]  wrWay;
    logic [59:0] wrBia;
    logic [63:0] wrTarget;
    logic        busy;
    logic        done;
  } resp_t;

  typedef struct {
    string name;
    stim_t in;
    resp_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        arst;
  logic        stallFetch;
  logic        updValid;
  logic        updReady;
  logic        updTaken;
  logic [1:0]  updWay;
  logic [1:0]  updIndex;
  logic [59:0] updBia;
  logic [63:0] updTarget;
  logic        flushReq;
  logic        flushBusy;
  logic        flushDone;
  logic        wrEn;
  logic        wrValid;
  logic [1:0]  wrIndex;
  logic [1:0]  wrWay;
  logic [59:0] wrBia;
  logic [63:0] wrTarget;

  int vecCount  = 0;
  int missCount = 0;
  vec_t vecs [12];

  always #5 clk = ~clk;

  btb_update_ctrl dut (
    .i_clk        (clk),
    .i_arst       (arst),
    .i_stall_fetch(stallFetch),
    .i_upd_valid  (updValid),
    .o_upd_ready  (updReady),
    .i_upd_taken  (updTaken),
    .i_upd_way    (updWay),
    .i_upd_index  (updIndex),
    .i_upd_bia    (updBia),
    .i_upd_target (updTarget),
    .i_flush_req  (flushReq),
    .o_flush_busy (flushBusy),
    .o_flush_done (flushDone),
    .o_wr_en      (wrEn),
    .o_wr_valid   (wrValid),
    .o_wr_index   (wrIndex),
    .o_wr_way     (wrWay),
    .o_wr_bia     (wrBia),
    .o_wr_target  (wrTarget)
  );

  function automatic stim_t nop(input logic stall);
    stim_t s;
    s       = '0;
    s.stall = stall;
    return s;
  endfunction

  function automatic stim_t upd(input logic stall, input logic taken, input logic [1:0] way,
                                input logic [1:0] index, input logic [59:0] bia, input logic [63:0] target);
    stim_t s;
    s        = '0;
    s.stall  = stall;
    s.valid  = 1'b1;
    s.taken  = taken;
    s.way    = way;
    s.index  = index;
    s.bia    = bia;
    s.target = target;
    return s;
  endfunction

  function automatic stim_t flushStim(input logic stall, input logic withUpd);
    stim_t s;
    s        = '0;
    s.stall  = stall;
    s.flush  = 1'b1;
    s.valid  = withUpd;
    s.taken  = withUpd;
    s.index  = 2'd3;
    s.way    = 2'd3;
    s.bia    = 60'hBAD;
    s.target = 64'hBAD0;
    return s;
  endfunction

  function automatic resp_t idle(input logic ready);
    resp_t r;
    r         = '0;
    r.ready   = ready;
    r.wrValid = 1'b1;
    return r;
  endfunction

  function automatic resp_t wr(input logic ready, input logic [1:0] way, input logic [1:0] index,
                               input logic [59:0] bia, input logic [63:0] target);
    resp_t r;
    r          = '0;
    r.ready    = ready;
    r.wrEn     = 1'b1;
    r.wrValid  = 1'b1;
    r.wrWay    = way;
    r.wrIndex  = index;
    r.wrBia    = bia;
    r.wrTarget = target;
    return r;
  endfunction

  function automatic resp_t inv(input logic [1:0] index);
    resp_t r;
    r         = '0;
    r.wrEn    = 1'b1;
    r.wrIndex = index;
    r.busy    = 1'b1;
    return r;
  endfunction

  function automatic resp_t doneResp();
    resp_t r;
    r         = '0;
    r.wrValid = 1'b1;
    r.done    = 1'b1;
    return r;
  endfunction

  task automatic applyStimulus(input stim_t s);
    stallFetch = s.stall;
    updValid   = s.valid;
    updTaken   = s.taken;
    updWay     = s.way;
    updIndex   = s.index;
    updBia     = s.bia;
    updTarget  = s.target;
    flushReq   = s.flush;
  endtask

  task automatic checkOutput(input string name, input resp_t exp);
    resp_t act;
    act.ready    = updReady;
    act.wrEn     = wrEn;
    act.wrValid  = wrValid;
    act.wrIndex  = wrIndex;
    act.wrWay    = wrWay;
    act.wrBia    = wrBia;
    act.wrTarget = wrTarget;
    act.busy     = flushBusy;
    act.done     = flushDone;
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive after the falling edge, check combinational outputs before the rising edge.
  task automatic step(input string name, input stim_t s, input resp_t exp);
    @(negedge clk);
    applyStimulus(s);
    #2;
    checkOutput(name, exp);
  endtask

  initial begin
    arst = 1'b1;
    applyStimulus(nop(1'b0));
    #2;
    checkOutput("reset", idle(1'b1));
    @(negedge clk);
    arst = 1'b0;

    vecs[0]  = '{"idle",        nop(1'b0), idle(1'b1)};
    vecs[1]  = '{"takenA",      upd(1'b0, 1'b1, 2'd1, 2'd2, 60'h123, 64'h8000_0040), idle(1'b1)};
    vecs[2]  = '{"writeA",      nop(1'b0), wr(1'b1, 2'd1, 2'd2, 60'h123, 64'h8000_0040)};
    vecs[3]  = '{"drainedA",    nop(1'b0), idle(1'b1)};
    vecs[4]  = '{"notTaken",    upd(1'b0, 1'b0, 2'd3, 2'd1, 60'h55, 64'h1234), idle(1'b1)};
    vecs[5]  = '{"ntNoWrite1",  nop(1'b0), idle(1'b1)};
    vecs[6]  = '{"ntNoWrite2",  nop(1'b0), idle(1'b1)};
    vecs[7]  = '{"stalledPush", upd(1'b1, 1'b1, 2'd2, 2'd3, 60'hAB, 64'hDEAD_BEEF_0000_0010), idle(1'b1)};
    vecs[8]  = '{"stallHold",   nop(1'b1), idle(1'b1)};
    vecs[9]  = '{"releasePush", upd(1'b0, 1'b1, 2'd0, 2'd0, 60'h1, 64'h100),
                 wr(1'b1, 2'd2, 2'd3, 60'hAB, 64'hDEAD_BEEF_0000_0010)};
    vecs[10] = '{"writeB",      nop(1'b0), wr(1'b1, 2'd0, 2'd0, 60'h1, 64'h100)};
    vecs[11] = '{"drainedB",    nop(1'b0), idle(1'b1)};
    for (int i = 0; i < 12; i++) step(vecs[i].name, vecs[i].in, vecs[i].exp);

    // Stall held: four fill the FIFO, fifth waits; release drains in order.
    for (int k = 0; k < 4; k++) begin
      step($sformatf("fill%0d", k),
           upd(1'b1, 1'b1, 2'(3 - k), 2'(k), 60'(100 + k), 64'h4000_0000 + 64'(k * 16)), idle(1'b1));
    end
    step("fullHold", upd(1'b1, 1'b1, 2'd3, 2'd0, 60'd104, 64'h4000_0040), idle(1'b0));
    step("release0", upd(1'b0, 1'b1, 2'd3, 2'd0, 60'd104, 64'h4000_0040),
         wr(1'b0, 2'd3, 2'd0, 60'd100, 64'h4000_0000));
    step("release1", upd(1'b0, 1'b1, 2'd3, 2'd0, 60'd104, 64'h4000_0040),
         wr(1'b1, 2'd2, 2'd1, 60'd101, 64'h4000_0010));
    step("release2", nop(1'b0), wr(1'b1, 2'd1, 2'd2, 60'd102, 64'h4000_0020));
    step("release3", nop(1'b0), wr(1'b1, 2'd0, 2'd3, 60'd103, 64'h4000_0030));
    step("release4", nop(1'b0), wr(1'b1, 2'd3, 2'd0, 60'd104, 64'h4000_0040));
    step("fillEmpty", nop(1'b0), idle(1'b1));

    // Flush with two queued entries; requests and updates during the walk are ignored.
    step("fq0",      upd(1'b1, 1'b1, 2'd1, 2'd1, 60'hF0, 64'hF000), idle(1'b1));
    step("fq1",      upd(1'b1, 1'b1, 2'd2, 2'd2, 60'hF1, 64'hF100), idle(1'b1));
    step("fReq",     flushStim(1'b1, 1'b1), idle(1'b0));
    step("fInv0",    flushStim(1'b1, 1'b0), inv(2'd0));
    step("fInv1",    upd(1'b1, 1'b1, 2'd1, 2'd1, 60'hF2, 64'hF200), inv(2'd1));
    step("fInv2",    nop(1'b1), inv(2'd2));
    step("fInv3",    nop(1'b0), inv(2'd3));
    step("fDone",    flushStim(1'b0, 1'b0), doneResp());
    step("fReady",   nop(1'b0), idle(1'b1));
    step("fNoStale", nop(1'b0), idle(1'b1));

    // Asynchronous reset in the second walk cycle.
    step("rReq",  flushStim(1'b0, 1'b0), idle(1'b0));
    step("rInv0", nop(1'b0), inv(2'd0));
    step("rInv1", nop(1'b0), inv(2'd1));
    arst = 1'b1;
    #1;
    checkOutput("rAsync", idle(1'b1));
    @(negedge clk);
    arst = 1'b0;
    step("rIdle", nop(1'b0), idle(1'b1));

    // Asynchronous reset with an entry queued: the entry is lost.
    step("rdPush", upd(1'b1, 1'b1, 2'd2, 2'd1, 60'hC0, 64'hC000), idle(1'b1));
    step("rdHold", nop(1'b1), idle(1'b1));
    arst = 1'b1;
    #1;
    checkOutput("rdAsync", idle(1'b1));
    @(negedge clk);
    arst = 1'b0;
    step("rdNoWrite", nop(1'b0), idle(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
